tdm_demux_4ch: RTL
==================

// Module: tdm_demux_4ch
// PURPOSE
//  Receive-end counterpart of the signal generator's 4:1 channel mux: takes a framed TDM sample
//  stream (one sample per slot, frame marked by in_sync) and distributes it into NUM_CH registered
//  channel outputs with per-channel valid strobes. Tracks frame alignment, flags sync errors and
//  re-hunts on loss of lock. Sits between the serial sample link and per-channel processing.
// PARAMETERS
//  DATA_W  8  sample width in bits
//  NUM_CH  4  slots per frame / output channels; power of two, >= 2; SLOT_W = $clog2(NUM_CH)
// PORTS
//  clk        in   1              single clock, all logic rising-edge
//  rst        in   1              asynchronous, active-high reset
//  in_valid   in   1              sample present on in_data this cycle (no backpressure)
//  in_data    in   DATA_W         sample
//  in_sync    in   1              qualifies in_valid: this sample is slot 0 of a frame
//  hunt_req   in   1              synchronous request to drop lock and return to HUNT
//  ch_data    out  NUM_CH*DATA_W  channel k at [k*DATA_W +: DATA_W], holds last written sample
//  ch_valid   out  NUM_CH         1-cycle pulse on bit k when ch_data[k] updated
//  frame_done out  1              1-cycle pulse when last slot (NUM_CH-1) written
//  locked     out  1              1 while FSM in LOCKED
//  sync_err   out  1              1-cycle pulse on any alignment error
// BEHAVIOUR
//  - Reset: FSM=HUNT, slot=0, ch_data=0, ch_valid=0, frame_done=0, locked=0, sync_err=0.
//  - All outputs registered; sample accepted in cycle N appears on ch_data/ch_valid in cycle N+1.
//  - in_sync without in_valid is ignored in all states.
//  - HUNT: in_valid&!in_sync -> sample dropped, no outputs. in_valid&in_sync -> write ch0,
//    slot<=1, FSM<=LOCKED (locked=1 from N+1).
//  - LOCKED, in_valid:
//    slot==0 & in_sync   -> write ch0, slot<=1.
//    slot==0 & !in_sync  -> missing sync: sample dropped, sync_err pulse, FSM<=HUNT, slot<=0.
//    slot!=0 & !in_sync  -> write ch[slot]; slot==NUM_CH-1 -> frame_done pulse, slot<=0 (wrap),
//                           else slot<=slot+1.
//    slot!=0 & in_sync   -> early sync: sync_err pulse, realign: write ch0, slot<=1, stay LOCKED;
//                           partial frame discarded, no frame_done.
//  - LOCKED, !in_valid: no state change, strobes low; ch_data holds.
//  - hunt_req has priority over same-cycle in_valid: sample ignored, FSM<=HUNT, slot<=0,
//    no sync_err; ch_data retains values.
//  - Exactly one ch_valid bit high per accepted sample; never more than one.
//  - Reset mid-frame: all state cleared immediately (async); resumes only on next in_sync.
// CONFIGURATION
//  TDM_DEMUX_ERRCNT_EN defined: adds output err_count [7:0], +1 per sync_err pulse, saturates
//  at 255, cleared only by rst. Not defined: port and counter absent; all else identical.
// STRUCTURE
//  - Package tdm_pkg: FSM state enum {HUNT, LOCKED}, default DATA_W/NUM_CH constants.
//  - One sub-module tdm_slot_counter: SLOT_W counter with clear, load-1, increment and
//    last-slot flag; the FSM, channel registers and strobes live in the top.
// TESTING
//  1 Reset then 4 samples A0,B1,C2,D3 with in_sync on A0 -> ch_valid 0001,0010,0100,1000 at
//    N+1..N+4, ch_data={D3,C2,B1,A0}, frame_done on 4th, locked=1, sync_err=0.
//  2 Samples before any sync (0x11,0x22) -> no ch_valid, locked=0; then sync 0x33 -> ch0=0x33.
//  3 Locked, sync asserted at slot 2 on 0x55 -> sync_err pulse, ch0=0x55, next sample to ch1,
//    no frame_done for broken frame.
//  4 Locked, slot 0 sample without sync -> sync_err, locked=0, ch_data unchanged.
//  5 Gaps (in_valid low 3 cycles mid-frame) and in_sync with in_valid=0 -> no effect, frame
//    completes normally; hunt_req with in_valid same cycle -> sample ignored, locked=0.
//  6 ERRCNT build: 260 forced sync errors -> err_count=255; async rst mid-frame -> all zero.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM sample demultiplexer.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 4;

endpackage

// File: rtl/tdm_slot_counter.sv
// Frame slot position counter: clear, load-1 (slot 0 just consumed), increment with
// natural power-of-two wrap, and a flag marking the final slot of the frame.
module tdm_slot_counter #(
    parameter int NUM_CH = 4,
    parameter int SLOT_W = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot,
    output logic              last
);

    logic [SLOT_W-1:0] slot_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_reg <= '0;
        end else if (clr) begin
            slot_reg <= '0;
        end else if (load1) begin
            slot_reg <= SLOT_W'(1);
        end else if (inc) begin
            slot_reg <= slot_reg + SLOT_W'(1);
        end
    end

    assign slot = slot_reg;
    assign last = (slot_reg == SLOT_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux_4ch.sv
// Framed TDM sample stream to NUM_CH registered channels with alignment tracking.
// Optional TDM_DEMUX_ERRCNT_EN adds a saturating sync-error counter output.
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SLOT_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sync,
    input  logic                     hunt_req,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic                     frame_done,
    output logic                     locked,
`ifdef TDM_DEMUX_ERRCNT_EN
    output logic                     sync_err,
    output logic [7:0]               err_count
`else
    output logic                     sync_err
`endif
);

    state_t            state_reg, state_next;
    logic              locked_reg, sync_err_reg, frame_done_reg;
    logic              wr_en, err_next, fdone_next;
    logic [SLOT_W-1:0] wr_sel, slot;
    logic              slot_last, cnt_clr, cnt_load1, cnt_inc;

    tdm_slot_counter #(
        .NUM_CH (NUM_CH),
        .SLOT_W (SLOT_W)
    ) u_slot (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .slot  (slot),
        .last  (slot_last)
    );

    // hunt_req outranks any sample arriving in the same cycle
    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        wr_sel     = '0;
        err_next   = 1'b0;
        fdone_next = 1'b0;
        cnt_clr    = 1'b0;
        cnt_load1  = 1'b0;
        cnt_inc    = 1'b0;
        if (hunt_req) begin
            state_next = HUNT;
            cnt_clr    = 1'b1;
        end else if (in_valid) begin
            case (state_reg)
                HUNT: begin
                    if (in_sync) begin
                        wr_en      = 1'b1;
                        cnt_load1  = 1'b1;
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot == '0) begin
                        if (in_sync) begin
                            wr_en     = 1'b1;
                            cnt_load1 = 1'b1;
                        end else begin
                            err_next   = 1'b1;
                            cnt_clr    = 1'b1;
                            state_next = HUNT;
                        end
                    end else if (in_sync) begin
                        // early sync: realign on this sample, drop the partial frame
                        err_next  = 1'b1;
                        wr_en     = 1'b1;
                        cnt_load1 = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        wr_sel     = slot;
                        cnt_inc    = 1'b1;
                        fdone_next = slot_last;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= HUNT;
            locked_reg     <= 1'b0;
            sync_err_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            locked_reg     <= (state_next == LOCKED);
            sync_err_reg   <= err_next;
            frame_done_reg <= fdone_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] data_reg;
            logic              valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= wr_en && (wr_sel == SLOT_W'(gi));
                    if (wr_en && (wr_sel == SLOT_W'(gi))) begin
                        data_reg <= in_data;
                    end
                end
            end

            assign ch_data[gi*DATA_W +: DATA_W] = data_reg;
            assign ch_valid[gi]                 = valid_reg;
        end
    endgenerate

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_reg <= '0;
        end else if (err_next && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign err_count = err_count_reg;
`endif

    assign locked     = locked_reg;
    assign sync_err   = sync_err_reg;
    assign frame_done = frame_done_reg;

endmodule
